// File: rtl/aui_pkg.sv
// Shared constants, FSM state type and frame-quota helper for the 1.6T AUI TX chain.
package aui_pkg;

    localparam int BITS_BLOCK       = 257;
    localparam int BLOCKS_PER_FRAME = 40;
    localparam int AM_MAPPED_WIDTH  = BITS_BLOCK * BLOCKS_PER_FRAME;
    localparam int LANE_WIDTH       = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    // Blocks accepted per frame across both flows; AM frames lose am_slots per flow.
    function automatic int quota(input logic am, input int bpf, input int am_slots);
        return am ? 2 * (bpf - am_slots) : 2 * bpf;
    endfunction

endpackage

// File: rtl/aui_tx_sequencer_if.sv
// Control/status bundle between the TX sequencer and the block source / back end.
interface aui_tx_sequencer_if #(
    parameter int IDX_W = 2
);
    logic             i_start;
    logic             i_stop;
    logic             i_src_valid;
    logic             i_rs_ready;
    logic             o_src_ready;
    logic             o_flow_sel;
    logic             o_pair_valid;
    logic             o_frame_valid;
    logic             o_am_frame;
    logic [IDX_W-1:0] o_frame_idx;
    logic             o_busy;
    logic             o_ovf_err;

    // master: the sequencer itself; slave: the surrounding datapath driving requests
    modport master (
        input  i_start, i_stop, i_src_valid, i_rs_ready,
        output o_src_ready, o_flow_sel, o_pair_valid, o_frame_valid,
               o_am_frame, o_frame_idx, o_busy, o_ovf_err
    );

    modport slave (
        output i_start, i_stop, i_src_valid, i_rs_ready,
        input  o_src_ready, o_flow_sel, o_pair_valid, o_frame_valid,
               o_am_frame, o_frame_idx, o_busy, o_ovf_err
    );
endinterface

// File: rtl/aui_frame_counter.sv
// Block/flow/frame bookkeeping: counts accepts, alternates flows, wraps the AM period
// and produces the registered pair and frame pulses.
module aui_frame_counter #(
    parameter int BLOCKS_PER_FRAME = 40,
    parameter int AM_SLOTS         = 2,
    parameter int AM_INTERVAL      = 4,
    parameter int IDX_W            = 2,
    parameter int CNT_W            = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             accept,
    output logic             frame_start,
    output logic             frame_last,
    output logic             flow_sel,
    output logic             pair_valid,
    output logic             frame_valid,
    output logic             am_frame,
    output logic [IDX_W-1:0] frame_idx
);
    import aui_pkg::*;

    localparam logic [CNT_W-1:0] LAST_NORM = CNT_W'(quota(1'b0, BLOCKS_PER_FRAME, AM_SLOTS) - 1);
    localparam logic [CNT_W-1:0] LAST_AM   = CNT_W'(quota(1'b1, BLOCKS_PER_FRAME, AM_SLOTS) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(AM_INTERVAL - 1);

    logic [CNT_W-1:0] blk_cnt;
    logic [IDX_W-1:0] idx_nxt;
    logic             pair_vld_p1;
    logic             frame_vld_p1;

    always_comb begin
        frame_start = (blk_cnt == '0);
        frame_last  = (blk_cnt == (am_frame ? LAST_AM : LAST_NORM));
        idx_nxt     = (frame_idx == IDX_LAST) ? '0 : frame_idx + IDX_W'(1);
    end

    // Stage p1: pulses land one cycle after the accept that completes a pair or frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt      <= '0;
            flow_sel     <= 1'b0;
            frame_idx    <= '0;
            am_frame     <= 1'b0;
            pair_vld_p1  <= 1'b0;
            frame_vld_p1 <= 1'b0;
        end else begin
            pair_vld_p1  <= accept & flow_sel;
            frame_vld_p1 <= accept & frame_last;
            if (clear) begin
                blk_cnt   <= '0;
                flow_sel  <= 1'b0;
                frame_idx <= '0;
                am_frame  <= 1'b0;
            end else if (start) begin
                blk_cnt   <= '0;
                flow_sel  <= 1'b0;
                frame_idx <= '0;
                am_frame  <= 1'b1;
            end else if (accept) begin
                if (frame_last) begin
                    blk_cnt   <= '0;
                    flow_sel  <= 1'b0;
                    frame_idx <= idx_nxt;
                    am_frame  <= (idx_nxt == '0);
                end else begin
                    blk_cnt  <= blk_cnt + CNT_W'(1);
                    flow_sel <= ~flow_sel;
                end
            end
        end
    end

    assign pair_valid  = pair_vld_p1;
    assign frame_valid = frame_vld_p1;

endmodule

// File: rtl/aui_tx_sequencer.sv
// Pacing controller for the AUI TX chain: throttles the block source, waits on the
// RS back end at frame starts, honours stop at frame end and flags source overflow.
module aui_tx_sequencer #(
    parameter int BLOCKS_PER_FRAME = aui_pkg::BLOCKS_PER_FRAME,
    parameter int AM_SLOTS         = 2,
    parameter int AM_INTERVAL      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    aui_tx_sequencer_if.master     bus
);
    import aui_pkg::*;

    localparam int IDX_W = (AM_INTERVAL > 1) ? $clog2(AM_INTERVAL) : 1;
    localparam int CNT_W = $clog2(2 * BLOCKS_PER_FRAME);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       stop_pend;
    logic       stop_eff;
    logic       frame_start;
    logic       frame_last;
    logic       src_ready;
    logic       busy;
    logic       accept;
    logic       start_now;
    logic       stop_now;
    logic       ovf_err;

    assign stop_eff = stop_pend | bus.i_stop;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.i_start) state_nxt = RUN;
            RUN: begin
                if (accept && frame_last && stop_eff)   state_nxt = IDLE;
                else if (frame_start && !bus.i_rs_ready) state_nxt = WAIT;
            end
            WAIT: begin
                // WAIT is only entered at a frame boundary, so a stop can leave at once
                if (stop_eff)            state_nxt = IDLE;
                else if (bus.i_rs_ready) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        src_ready = (state == RUN) && !(frame_start && !bus.i_rs_ready);
        accept    = bus.i_src_valid & src_ready;
        start_now = (state == IDLE) & bus.i_start;
        stop_now  = busy && (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_pend <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (stop_now)
                stop_pend <= 1'b0;
            else if ((busy || start_now) && bus.i_stop)
                stop_pend <= 1'b1;
            if (busy && bus.i_src_valid && !src_ready)
                ovf_err <= 1'b1;
        end
    end

    aui_frame_counter #(
        .BLOCKS_PER_FRAME (BLOCKS_PER_FRAME),
        .AM_SLOTS         (AM_SLOTS),
        .AM_INTERVAL      (AM_INTERVAL),
        .IDX_W            (IDX_W),
        .CNT_W            (CNT_W)
    ) u_frame_counter (
        .clk         (clk),
        .rst         (rst),
        .start       (start_now),
        .clear       (stop_now),
        .accept      (accept),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .flow_sel    (bus.o_flow_sel),
        .pair_valid  (bus.o_pair_valid),
        .frame_valid (bus.o_frame_valid),
        .am_frame    (bus.o_am_frame),
        .frame_idx   (bus.o_frame_idx)
    );

    assign bus.o_src_ready = src_ready;
    assign bus.o_busy      = busy;
    assign bus.o_ovf_err   = ovf_err;

endmodule

// File: tb/tb_aui_tx_sequencer.sv
// Directed bench for aui_tx_sequencer: default configuration plus an
// AM_INTERVAL=1 / AM_SLOTS=0 instance.
module tb_aui_tx_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aui_tx_sequencer_if #(.IDX_W(2)) bus1 ();
    aui_tx_sequencer_if #(.IDX_W(1)) bus2 ();

    aui_tx_sequencer #(.BLOCKS_PER_FRAME(40), .AM_SLOTS(2), .AM_INTERVAL(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    aui_tx_sequencer #(.BLOCKS_PER_FRAME(40), .AM_SLOTS(0), .AM_INTERVAL(1)) u_dut_am1 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // scoreboard for u_dut
    int acc         = 0;
    int pairs       = 0;
    int exp_idx     = 0;
    int exp_flow    = 0;
    int flow_err    = 0;
    int frames_seen = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic mdl_reset();
        acc = 0; pairs = 0; exp_idx = 0; exp_flow = 0; flow_err = 0;
    endtask

    function automatic logic [9:0] outs1();
        return {bus1.o_src_ready, bus1.o_flow_sel, bus1.o_pair_valid, bus1.o_frame_valid,
                bus1.o_am_frame, bus1.o_frame_idx, bus1.o_busy, bus1.o_ovf_err};
    endfunction

    // One clock: sample u_dut at the negedge, then return 1 time unit after the posedge.
    task automatic step();
        @(negedge clk);
        if (bus1.o_pair_valid) pairs++;
        if (bus1.o_frame_valid) begin
            chk_eq("frame_len",   acc,      (exp_idx == 0) ? 76 : 80);
            chk_eq("frame_pairs", pairs,    (exp_idx == 0) ? 38 : 40);
            chk_eq("flow_alt",    flow_err, 0);
            acc = 0; pairs = 0; flow_err = 0; exp_flow = 0;
            exp_idx = (exp_idx + 1) % 4;
            frames_seen++;
        end
        if (bus1.i_src_valid && bus1.o_src_ready) begin
            if (acc == 0) begin
                chk_eq("am_frame",  bus1.o_am_frame,  (exp_idx == 0));
                chk_eq("frame_idx", bus1.o_frame_idx, exp_idx);
            end
            if (bus1.o_flow_sel != exp_flow[0]) flow_err++;
            exp_flow ^= 1;
            acc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        int fs;
        int fv;
        int a2, f2, am_low, idx_bad;

        bus1.i_start = 0; bus1.i_stop = 0; bus1.i_src_valid = 0; bus1.i_rs_ready = 0;
        bus2.i_start = 0; bus2.i_stop = 0; bus2.i_src_valid = 0; bus2.i_rs_ready = 0;

        // reset and idle behaviour
        rst = 1'b1;
        step(); step();
        chk_eq("reset_outs", outs1(), 0);
        rst = 1'b0;
        bus1.i_src_valid = 1;
        step(); step();
        chk_eq("idle_no_ovf", bus1.o_ovf_err,   0);
        chk_eq("idle_rdy",    bus1.o_src_ready, 0);

        // continuous stream: five frames, idx 0,1,2,3,0
        mdl_reset();
        bus1.i_rs_ready = 1;
        bus1.i_start = 1;
        step();
        bus1.i_start = 0;
        chk_eq("start_busy", bus1.o_busy, 1);
        g = 0;
        while (frames_seen < 5 && g < 1000) begin step(); g++; end
        chk_eq("stream_frames", frames_seen, 5);

        // ~30% source bubbles over four more frames
        fs = frames_seen + 4;
        g = 0;
        while (frames_seen < fs && g < 3000) begin
            bus1.i_src_valid = ($urandom_range(0, 99) >= 30);
            step(); g++;
        end
        chk_eq("bubble_frames", frames_seen, fs);
        chk_eq("bubble_no_ovf", bus1.o_ovf_err, 0);

        // back end not ready at a frame boundary for 5 cycles
        bus1.i_src_valid = 1;
        g = 0;
        do begin step(); g++; end while (!bus1.o_frame_valid && g < 200);
        chk_eq("wait_boundary", bus1.o_frame_valid, 1);
        for (int i = 0; i < 5; i++) begin
            bus1.i_rs_ready  = 0;
            bus1.i_src_valid = (i == 2);
            #1;
            chk_eq("wait_rdy_low", bus1.o_src_ready, 0);
            step();
        end
        chk_eq("wait_busy", bus1.o_busy,    1);
        chk_eq("wait_ovf",  bus1.o_ovf_err, 1);
        bus1.i_rs_ready  = 1;
        bus1.i_src_valid = 1;
        #1;
        chk_eq("wait_exit_rdy", bus1.o_src_ready, 0);
        step();
        #1;
        chk_eq("resume_rdy",  bus1.o_src_ready, 1);
        chk_eq("resume_flow", bus1.o_flow_sel,  0);

        // stop pulsed on the 10th accept of a frame
        g = 0;
        do begin step(); g++; end while (!bus1.o_frame_valid && g < 200);
        step();
        g = 0;
        while (acc < 9 && g < 100) begin step(); g++; end
        chk_eq("stop_at_acc", acc, 9);
        bus1.i_stop = 1;
        step();
        bus1.i_stop = 0;
        fs = frames_seen;
        g = 0;
        while (frames_seen == fs && g < 300) begin step(); g++; end
        chk_eq("stop_frame_done", frames_seen, fs + 1);
        chk_eq("stop_busy", bus1.o_busy,      0);
        chk_eq("stop_rdy",  bus1.o_src_ready, 0);
        step(); step();
        chk_eq("stop_stays_idle", bus1.o_busy, 0);

        // restart begins with an AM frame at idx 0
        mdl_reset();
        bus1.i_start = 1;
        step();
        bus1.i_start = 0;
        chk_eq("restart_am",  bus1.o_am_frame,  1);
        chk_eq("restart_idx", bus1.o_frame_idx, 0);
        chk_eq("restart_busy", bus1.o_busy,     1);

        // reset mid-frame at accept 50
        g = 0;
        while (acc < 50 && g < 200) begin step(); g++; end
        chk_eq("rst_at_acc", acc, 50);
        rst = 1'b1;
        step();
        chk_eq("midframe_rst_outs", outs1(), 0);
        rst = 1'b0;
        mdl_reset();
        fv = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus1.o_frame_valid) fv++;
        end
        chk_eq("no_partial_frame", fv, 0);
        bus1.i_src_valid = 0;

        // AM_INTERVAL=1, AM_SLOTS=0 instance: every frame is an 80-block AM frame
        bus2.i_rs_ready  = 1;
        bus2.i_src_valid = 1;
        bus2.i_start     = 1;
        step();
        bus2.i_start = 0;
        a2 = 0; f2 = 0; am_low = 0; idx_bad = 0;
        g = 0;
        while (f2 < 3 && g < 600) begin
            @(negedge clk);
            if (bus2.o_frame_valid) begin
                chk_eq("am1_frame_len", a2, 80);
                a2 = 0; f2++;
            end
            if (bus2.i_src_valid && bus2.o_src_ready) a2++;
            if (bus2.o_busy && !bus2.o_am_frame) am_low++;
            if (bus2.o_frame_idx != 1'b0) idx_bad++;
            @(posedge clk);
            #1;
            g++;
        end
        chk_eq("am1_frames",   f2,      3);
        chk_eq("am1_am_const", am_low,  0);
        chk_eq("am1_idx_zero", idx_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
